mem_port_arbiter: RTL and testbench

//  Shares the single memory port (clocked by B_CLK / MEM_CLK domain) between the instruction

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_rr.sv | 25 ++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM encoding, grant identifiers
// and the default memory-acknowledge timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } gnt_id_t;

  localparam int unsigned TO_CYC_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the requester that was not granted last. Purely combinational.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_id_t    last,
  output logic [1:0] gnt,
  output gnt_id_t    gnt_id
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    gnt_id = last;
    gnt    = 2'b00;
    case (req)
      2'b01:   gnt_id = GNT_IC;
      2'b10:   gnt_id = GNT_DC;
      2'b11:   gnt_id = (last == GNT_IC) ? GNT_DC : GNT_IC;
      default: gnt_id = last;
    endcase
    if (req != 2'b00) gnt = (gnt_id == GNT_DC) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-cache refill and D-cache paths, one
// single-word transaction at a time. Optional MEM_ACK timeout: ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_CYC = TO_CYC_DEFAULT
) (
  input  logic          B_CLK,
  input  logic          RST,
  input  logic          IC_REQ,
  input  logic [AW-1:0] IC_ADDR,
  output logic [DW-1:0] IC_RDATA,
  output logic          IC_ACK,
  input  logic          DC_REQ,
  input  logic          DC_WE,
  input  logic [AW-1:0] DC_ADDR,
  input  logic [DW-1:0] DC_WDATA,
  output logic [DW-1:0] DC_RDATA,
  output logic          DC_ACK,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic          MEM_ACK,
  output logic          ARB_ERR
);

  arb_state_t    state_q, state_d;
  gnt_id_t       last_q, last_d;
  logic [1:0]    rr_gnt;
  gnt_id_t       rr_gnt_id;
  logic          to_expire;

  logic          mem_req_d, mem_we_d, ic_ack_d, dc_ack_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, ic_rdata_d, dc_rdata_d, rsp_data;

  mem_arb_rr u_rr (
    .req    ({DC_REQ, IC_REQ}),
    .last   (last_q),
    .gnt    (rr_gnt),
    .gnt_id (rr_gnt_id)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge B_CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= GNT_DC;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // last_q doubles as the owner of the transaction in flight.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = MEM_REQ;
    mem_we_d    = MEM_WE;
    mem_addr_d  = MEM_ADDR;
    mem_wdata_d = MEM_WDATA;
    ic_rdata_d  = IC_RDATA;
    dc_rdata_d  = DC_RDATA;
    ic_ack_d    = 1'b0;
    dc_ack_d    = 1'b0;
    rsp_data    = MEM_ACK ? MEM_RDATA : '0;
    case (state_q)
      IDLE: begin
        if (rr_gnt != 2'b00) begin
          last_d    = rr_gnt_id;
          mem_req_d = 1'b1;
          state_d   = BUSY;
          if (rr_gnt[1]) begin
            mem_we_d    = DC_WE;
            mem_addr_d  = DC_ADDR;
            mem_wdata_d = DC_WDATA;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = IC_ADDR;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY: begin
        // MEM_ACK on the expiry edge still completes normally with real data.
        if (MEM_ACK || to_expire) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (last_q == GNT_DC) begin
            dc_ack_d   = 1'b1;
            dc_rdata_d = rsp_data;
          end else begin
            ic_ack_d   = 1'b1;
            ic_rdata_d = rsp_data;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge B_CLK or posedge RST) begin
    if (RST) begin
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      IC_RDATA  <= '0;
      DC_RDATA  <= '0;
      IC_ACK    <= 1'b0;
      DC_ACK    <= 1'b0;
    end else begin
      MEM_REQ   <= mem_req_d;
      MEM_WE    <= mem_we_d;
      MEM_ADDR  <= mem_addr_d;
      MEM_WDATA <= mem_wdata_d;
      IC_RDATA  <= ic_rdata_d;
      DC_RDATA  <= dc_rdata_d;
      IC_ACK    <= ic_ack_d;
      DC_ACK    <= dc_ack_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TO_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;

  // Counts completed BUSY cycles; expiry is the edge ending the TO_CYC-th one.
  always_ff @(posedge B_CLK or posedge RST) begin
    if (RST)                  to_cnt_q <= '0;
    else if (state_q != BUSY) to_cnt_q <= '0;
    else                      to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign to_expire = (state_q == BUSY) && (to_cnt_q == CNT_W'(TO_CYC - 1));

  always_ff @(posedge B_CLK or posedge RST) begin
    if (RST) ARB_ERR <= 1'b0;
    else     ARB_ERR <= to_expire && !MEM_ACK;
  end
`else
  assign to_expire = 1'b0;
  assign ARB_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected ACKs are queued when a request
// is raised and popped by a monitor as the DUT acknowledges.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          b_clk = 1'b0;
  logic          rst   = 1'b1;
  logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic [DW-1:0] dc_wdata = '0, mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          ic_ack, dc_ack, mem_req, mem_we, arb_err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TO_CYC(4)) dut (
    .B_CLK     (b_clk),
    .RST       (rst),
    .IC_REQ    (ic_req),
    .IC_ADDR   (ic_addr),
    .IC_RDATA  (ic_rdata),
    .IC_ACK    (ic_ack),
    .DC_REQ    (dc_req),
    .DC_WE     (dc_we),
    .DC_ADDR   (dc_addr),
    .DC_WDATA  (dc_wdata),
    .DC_RDATA  (dc_rdata),
    .DC_ACK    (dc_ack),
    .MEM_REQ   (mem_req),
    .MEM_WE    (mem_we),
    .MEM_ADDR  (mem_addr),
    .MEM_WDATA (mem_wdata),
    .MEM_RDATA (mem_rdata),
    .MEM_ACK   (mem_ack),
    .ARB_ERR   (arb_err)
  );

  always #5 b_clk = ~b_clk;

  typedef struct {
    bit            dc;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mem_auto = 1'b0;
  int   mem_lat  = 1;
  int   mem_wait = 0;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge b_clk);
  endtask

  // Scoreboard monitor: every ACK must match the oldest expected entry.
  always @(negedge b_clk) begin
    if (!rst) begin
      if (ic_ack || dc_ack) begin
        if (sb.size() == 0) begin
          check("spurious_ack", {ic_ack, dc_ack}, 2'b00);
        end else begin
          mon_e = sb.pop_front();
          check("ack_src", {ic_ack, dc_ack}, mon_e.dc ? 2'b01 : 2'b10);
          check("ack_rdata", mon_e.dc ? dc_rdata : ic_rdata, mon_e.rdata);
          check("ack_err", arb_err, mon_e.err);
        end
      end else begin
        check("err_quiet", arb_err, 1'b0);
      end
    end
  end

  // Auto-responding memory: acknowledges mem_lat cycles after MEM_REQ is seen.
  always @(negedge b_clk) begin
    if (mem_auto) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (mem_wait >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model(mem_addr);
          mem_wait  = 0;
        end else begin
          mem_wait++;
        end
      end
    end
  end

  // Both requesters held high; each drops its request in its n-th ACK cycle.
  task automatic run_both(input int n);
    int nic = 0;
    int ndc = 0;
    ic_req = 1'b1;
    dc_req = 1'b1;
    for (int c = 0; c < 200 && (nic < n || ndc < n); c++) begin
      tick();
      if (ic_ack) begin nic++; if (nic == n) ic_req = 1'b0; end
      if (dc_ack) begin ndc++; if (ndc == n) dc_req = 1'b0; end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    check("both_ack_counts", {32'(nic), 32'(ndc)}, {32'(n), 32'(n)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_ctrl", {mem_req, mem_we, ic_ack, dc_ack, arb_err}, 5'b0);
    check("rst_rdata", {ic_rdata, dc_rdata}, 64'h0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 64'h0);
    rst = 1'b0;
    tick();

    // IC read, MEM_ACK two cycles after the grant
    ic_addr = 32'h0040_0000;
    ic_req  = 1'b1;
    sb.push_back('{1'b0, 32'h8C01_0004, 1'b0});
    tick();
    check("ic_rd_req", {mem_req, mem_we}, 2'b10);
    check("ic_rd_addr", {mem_addr, mem_wdata}, {32'h0040_0000, 32'h0});
    tick();
    check("ic_rd_hold", {mem_req, ic_ack, dc_ack}, 3'b100);
    mem_ack   = 1'b1;
    mem_rdata = 32'h8C01_0004;
    tick();
    mem_ack = 1'b0;
    check("ic_rd_ack", {ic_ack, dc_ack, mem_req}, 3'b100);
    ic_req = 1'b0;
    tick();
    check("ic_rd_pulse", {ic_ack, dc_ack}, 2'b00);
    check("ic_rd_keep", ic_rdata, 32'h8C01_0004);

    // DC write, bus held stable until MEM_ACK
    dc_we     = 1'b1;
    dc_addr   = 32'h1001_0000;
    dc_wdata  = 32'hDEAD_BEEF;
    dc_req    = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    sb.push_back('{1'b1, 32'h0BAD_F00D, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dc_wr_bus", {mem_req, mem_we, mem_addr, mem_wdata},
            {1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF});
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("dc_wr_ack", {ic_ack, dc_ack, mem_req}, 3'b010);
    dc_req = 1'b0;
    dc_we  = 1'b0;
    tick();
    check("dc_wr_pulse", {dc_ack, ic_rdata}, {1'b0, 32'h8C01_0004});

    // Contention: last grant was DC, so IC, DC, IC, DC
    mem_auto = 1'b1;
    ic_addr  = 32'h0000_0100;
    dc_addr  = 32'h0000_0200;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, mem_model(32'h0000_0100), 1'b0});
      sb.push_back('{1'b1, mem_model(32'h0000_0200), 1'b0});
    end
    run_both(2);
    tick(2);
    mem_auto = 1'b0;

    // MEM_ACK in IDLE and in RESP is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("ack_in_idle", {mem_req, ic_ack, dc_ack}, 3'b000);
    ic_addr = 32'h0000_0300;
    ic_req  = 1'b1;
    sb.push_back('{1'b0, 32'h0000_0077, 1'b0});
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0077;
    tick();
    check("resp_ack_seen", ic_ack, 1'b1);
    ic_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    check("ack_in_resp", {mem_req, ic_ack, dc_ack}, 3'b000);
    tick(2);
    check("ack_in_resp_late", {mem_req, ic_ack, dc_ack}, 3'b000);

    // Reset mid-BUSY on an IC grant, then the first tie must still go to IC
    ic_addr = 32'h0000_0400;
    ic_req  = 1'b1;
    tick(2);
    check("mid_busy", mem_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {mem_req, mem_we, ic_ack, dc_ack, arb_err}, 5'b0);
    check("rst_async_bus", {mem_addr, ic_rdata, dc_rdata}, 96'h0);
    ic_req = 1'b0;
    tick();
    rst     = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick(3);
    check("rst_no_ack", {mem_req, ic_ack, dc_ack}, 3'b000);
    mem_auto = 1'b1;
    sb.push_back('{1'b0, mem_model(32'h0000_0100), 1'b0});
    sb.push_back('{1'b1, mem_model(32'h0000_0200), 1'b0});
    ic_addr = 32'h0000_0100;
    run_both(1);
    tick(2);
    mem_auto = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Timeout after 4 BUSY cycles with no MEM_ACK
    ic_addr = 32'h0000_0500;
    ic_req  = 1'b1;
    sb.push_back('{1'b0, 32'h0, 1'b1});
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait", {mem_req, ic_ack, arb_err}, 3'b100);
    end
    tick();
    check("to_fire", {mem_req, ic_ack, arb_err, ic_rdata}, {3'b011, 32'h0});
    ic_req = 1'b0;
    tick();
    check("to_pulse", {ic_ack, arb_err}, 2'b00);

    // MEM_ACK on the expiry edge completes normally
    ic_req = 1'b1;
    sb.push_back('{1'b0, 32'h5A5A_5A5A, 1'b0});
    tick(4);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    tick();
    mem_ack = 1'b0;
    check("to_race", {ic_ack, arb_err, ic_rdata}, {2'b10, 32'h5A5A_5A5A});
    ic_req = 1'b0;
    tick();
`endif

    tick(3);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
